// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO: default widths, skid-buffer state
// encoding and the gray-to-binary helper used by level logic on either side.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDRESS_DEF    = 3;
    localparam int GRAY_MAX_W     = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    // Callers zero-extend narrower pointers; leading zeros leave the result unchanged.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Plain two-flop synchroniser for a gray-coded pointer crossing into clk.
// No logic sits between the flops, so each bit sees a full cycle to settle.
module fifo_sync_2ff
    import fifo_pkg::*;
#(
    parameter int WIDTH = ADDRESS_DEF + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // NOTE: every output of an always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // NOTE: flops use <= so both stages sample the pre-edge values and the chain shifts by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/fifo_wr_frontend.sv
// Write-domain front end of the async FIFO: 2-entry skid buffer driving Winc/Wdata,
// read-pointer synchroniser, and optional fill level enabled by `WR_LEVEL_EN.
module fifo_wr_frontend
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int Address    = ADDRESS_DEF,
    parameter int AF_THR     = 6
) (
    input  logic                  Wclk,
    input  logic                  Wrst,
    input  logic                  In_valid,
    input  logic [DATA_WIDTH-1:0] In_data,
    output logic                  In_ready,
    input  logic [Address:0]      Rptr,
    input  logic [Address:0]      Wptr,
    input  logic                  Wfull,
    output logic                  Winc,
    output logic [DATA_WIDTH-1:0] Wdata,
    output logic [Address:0]      Wq2_rptr,
    output logic [Address:0]      Wlevel,
    output logic                  Walmost_full
);

    localparam int PTR_W = Address + 1;

    skid_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] entry0_q, entry0_d;
    logic [DATA_WIDTH-1:0] entry1_q, entry1_d;
    logic                  in_ready_q, in_ready_d;
    logic                  push, pop;

    assign push = In_valid & in_ready_q;
    assign pop  = Winc;

    always_comb begin
        state_d  = state_q;
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    entry0_d = In_data;
                    state_d  = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    entry0_d = In_data;
                end else if (push) begin
                    entry1_d = In_data;
                    state_d  = TWO;
                end else if (pop) begin
                    state_d  = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    entry0_d = entry1_q;
                    state_d  = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Registered ready looks at the next state so TWO is never overrun.
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge Wclk or negedge Wrst) begin
        if (!Wrst) begin
            state_q    <= EMPTY;
            // NOTE: the two data entries are reset because Wdata is observable from reset; a RAM array would not be.
            entry0_q   <= '0;
            entry1_q   <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            entry0_q   <= entry0_d;
            entry1_q   <= entry1_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign In_ready = in_ready_q;
    assign Winc     = (state_q != EMPTY) & ~Wfull;
    assign Wdata    = entry0_q;

    fifo_sync_2ff #(
        .WIDTH (PTR_W)
    ) u_sync_rptr (
        .clk   (Wclk),
        .rst_n (Wrst),
        .d     (Rptr),
        .q     (Wq2_rptr)
    );

`ifdef WR_LEVEL_EN
    localparam logic [PTR_W-1:0] AF_THR_W = PTR_W'(AF_THR);

    logic [PTR_W-1:0] wbin, rbin;
    logic [PTR_W-1:0] level_q, level_d;
    logic             almost_full_q, almost_full_d;

    // Modulo subtraction covers pointer wrap; the lagging Wq2_rptr makes this pessimistic.
    always_comb begin
        wbin          = PTR_W'(gray2bin(GRAY_MAX_W'(Wptr)));
        rbin          = PTR_W'(gray2bin(GRAY_MAX_W'(Wq2_rptr)));
        level_d       = wbin - rbin;
        almost_full_d = (level_d >= AF_THR_W);
    end

    always_ff @(posedge Wclk or negedge Wrst) begin
        if (!Wrst) begin
            level_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            level_q       <= level_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign Wlevel       = level_q;
    assign Walmost_full = almost_full_q;
`else
    logic unused_level_inputs;
    assign unused_level_inputs = (^Wptr) ^ (AF_THR != 0);

    assign Wlevel       = '0;
    assign Walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_frontend.sv
// Scoreboard bench for fifo_wr_frontend: driver queues accepted words, a negedge
// monitor checks handshake, write order, synchroniser delay and fill level.
module tb_fifo_wr_frontend;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int PW = AW + 1;

    logic          Wclk;
    logic          Wrst;
    logic          In_valid;
    logic [DW-1:0] In_data;
    logic          In_ready;
    logic [PW-1:0] Rptr;
    logic [PW-1:0] Wptr;
    logic          Wfull;
    logic          Winc;
    logic [DW-1:0] Wdata;
    logic [PW-1:0] Wq2_rptr;
    logic [PW-1:0] Wlevel;
    logic          Walmost_full;

    fifo_wr_frontend #(
        .DATA_WIDTH (DW),
        .Address    (AW),
        .AF_THR     (6)
    ) dut (
        .Wclk         (Wclk),
        .Wrst         (Wrst),
        .In_valid     (In_valid),
        .In_data      (In_data),
        .In_ready     (In_ready),
        .Rptr         (Rptr),
        .Wptr         (Wptr),
        .Wfull        (Wfull),
        .Winc         (Winc),
        .Wdata        (Wdata),
        .Wq2_rptr     (Wq2_rptr),
        .Wlevel       (Wlevel),
        .Walmost_full (Walmost_full)
    );

    initial Wclk = 1'b0;
    always #5 Wclk = ~Wclk;

    int            tests = 0;
    int            fails = 0;
    bit            mon_en = 1'b0;
    logic [DW-1:0] stim_q[$];
    logic [DW-1:0] exp_q[$];
    logic [PW-1:0] rptr_bin = '0;
    logic [PW-1:0] wptr_bin = '0;
    logic [PW-1:0] rp_h1, rp_h2;
    logic [PW-1:0] prev_wptr, prev_wq2;

    function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] from_gray(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        for (int i = 0; i < PW; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; a word leaves stim_q for exp_q only when the DUT takes it.
    task automatic cycle(input logic wf, input bit gap);
        @(posedge Wclk);
        #1;
        Wfull    = wf;
        Rptr     = to_gray(rptr_bin);
        Wptr     = to_gray(wptr_bin);
        In_valid = (stim_q.size() > 0) && !gap;
        In_data  = In_valid ? stim_q[0] : DW'($urandom);
        #7;
        if (In_valid && In_ready) exp_q.push_back(stim_q.pop_front());
    endtask

    task automatic do_reset();
        @(posedge Wclk);
        #3;
        mon_en   = 1'b0;
        Wrst     = 1'b0;
        In_valid = 1'b0;
        #1;
        check("rst_in_ready", 32'(In_ready), 32'd0);
        check("rst_winc", 32'(Winc), 32'd0);
        check("rst_wdata", 32'(Wdata), 32'd0);
        check("rst_wq2_rptr", 32'(Wq2_rptr), 32'd0);
        check("rst_wlevel", 32'(Wlevel), 32'd0);
        check("rst_walmost_full", 32'(Walmost_full), 32'd0);
        exp_q.delete();
        stim_q.delete();
        rptr_bin = '0;
        wptr_bin = '0;
        Rptr     = '0;
        Wptr     = '0;
        Wfull    = 1'b0;
        repeat (2) @(posedge Wclk);
        #3 Wrst = 1'b1;
        @(posedge Wclk);
        rp_h1     = Rptr;
        rp_h2     = '0;
        prev_wptr = Wptr;
        prev_wq2  = '0;
        mon_en    = 1'b1;
    endtask

    // Monitor: expectations come from the count of accepted-but-unwritten words.
    always @(negedge Wclk) begin
        logic [PW-1:0] lvl;
        if (mon_en) begin
            check("in_ready", 32'(In_ready), 32'(exp_q.size() < 2));
            check("winc", 32'(Winc), 32'(exp_q.size() > 0 && !Wfull));
            if (Winc && exp_q.size() > 0) check("wdata", 32'(Wdata), 32'(exp_q.pop_front()));
            check("wq2_rptr", 32'(Wq2_rptr), 32'(rp_h2));
            rp_h2 = rp_h1;
            rp_h1 = Rptr;
`ifdef WR_LEVEL_EN
            lvl = from_gray(prev_wptr) - from_gray(prev_wq2);
            check("wlevel", 32'(Wlevel), 32'(lvl));
            check("walmost_full", 32'(Walmost_full), 32'(lvl >= 6));
            prev_wptr = Wptr;
            prev_wq2  = Wq2_rptr;
`else
            lvl = '0;
            check("wlevel", 32'(Wlevel), 32'(lvl));
            check("walmost_full", 32'(Walmost_full), 32'd0);
`endif
        end
    end

    initial begin
        Wrst     = 1'b0;
        In_valid = 1'b0;
        In_data  = '0;
        Rptr     = '0;
        Wptr     = '0;
        Wfull    = 1'b0;
        do_reset();

        // Reset with two words held behind Wfull: nothing stale may come out afterwards.
        stim_q = '{8'hB1, 8'hB2};
        repeat (3) cycle(1'b1, 1'b0);
        check("t1_full_ready", 32'(In_ready), 32'd0);
        do_reset();
        repeat (3) cycle(1'b0, 1'b0);
        check("t1_no_stale_winc", 32'(Winc), 32'd0);

        // Streaming with Wfull low: first write one cycle after acceptance.
        for (int i = 1; i <= 8; i++) stim_q.push_back(DW'(i));
        cycle(1'b0, 1'b0);
        check("t2_winc_first", 32'(Winc), 32'd0);
        cycle(1'b0, 1'b0);
        check("t2_winc_second", 32'(Winc), 32'd1);
        check("t2_wdata_second", 32'(Wdata), 32'h01);
        repeat (10) cycle(1'b0, 1'b0);

        // Wfull held: two words fill the buffer, the third stalls, head stays put.
        stim_q = '{8'hA1, 8'hA2, 8'hA3};
        repeat (4) cycle(1'b1, 1'b0);
        check("t3_ready", 32'(In_ready), 32'd0);
        check("t3_winc", 32'(Winc), 32'd0);
        check("t3_head", 32'(Wdata), 32'hA1);
        repeat (6) cycle(1'b0, 1'b0);

        // Rptr 0000 -> 0001 reaches Wq2_rptr two edges after it is first sampled.
        rptr_bin = 4'd1;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check("t5_sync_one_edge", 32'(Wq2_rptr), 32'd0);
        cycle(1'b0, 1'b0);
        check("t5_sync_two_edges", 32'(Wq2_rptr), 32'd1);

`ifdef WR_LEVEL_EN
        do_reset();
        wptr_bin = 4'd8;
        repeat (3) cycle(1'b0, 1'b0);
        check("t6_level_wrap", 32'(Wlevel), 32'd8);
        check("t6_af_wrap", 32'(Walmost_full), 32'd1);
        wptr_bin = 4'd6;
        repeat (3) cycle(1'b0, 1'b0);
        check("t6_level_six", 32'(Wlevel), 32'd6);
        check("t6_af_six", 32'(Walmost_full), 32'd1);
        rptr_bin = 4'd1;
        cycle(1'b0, 1'b0);
        rptr_bin = 4'd2;
        repeat (5) cycle(1'b0, 1'b0);
        check("t6_level_four", 32'(Wlevel), 32'd4);
        check("t6_af_four", 32'(Walmost_full), 32'd0);
`endif

        // Randomised traffic with back-pressure, pointer motion and one mid-run reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            if (stim_q.size() < 3) stim_q.push_back(DW'($urandom));
            if ($urandom_range(3) == 0) rptr_bin = rptr_bin + 1'b1;
            if ($urandom_range(1) == 1) wptr_bin = wptr_bin + 1'b1;
            cycle($urandom_range(9) < 3, $urandom_range(4) == 0);
        end

        stim_q.delete();
        repeat (8) cycle(1'b0, 1'b0);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
